// File: rtl/parking_lot_ctrl_pkg.sv
// Shared types for the parking-lot controller: gate FSM states and sensor codes.
// Sensor codes are {outer, inner}, 1 = beam blocked.
package parking_pkg;

   typedef enum logic [2:0] {IDLE, EN1, EN2, EN3, EX1, EX2, EX3} gate_state_t;

   localparam logic [1:0] CLR  = 2'b00;
   localparam logic [1:0] OUT  = 2'b10;
   localparam logic [1:0] IN   = 2'b01;
   localparam logic [1:0] BOTH = 2'b11;

   // Sensor code a gate must be showing while it sits in a given state.
   function automatic logic [1:0] state_code(input gate_state_t s);
      case (s)
         EN1, EX3: state_code = OUT;
         EN2, EX2: state_code = BOTH;
         EN3, EX1: state_code = IN;
         default:  state_code = CLR;
      endcase
   endfunction

endpackage

// File: rtl/parking_lot_ctrl_if.sv
// Sensor inputs and occupancy outputs of the parking-lot controller.
// master = sensor/display side, slave = controller side.
interface parking_lot_ctrl_if #(
   parameter int NUM_GATES = 2,
   parameter int CAPACITY  = 16
);
   localparam int CNT_W = $clog2(CAPACITY + 1);

   logic [NUM_GATES-1:0] outer;
   logic [NUM_GATES-1:0] inner;
   logic [NUM_GATES-1:0] enter_pulse;
   logic [NUM_GATES-1:0] exit_pulse;
   logic [CNT_W-1:0]     count;
   logic                 full;
   logic                 empty;
   logic [NUM_GATES-1:0] gate_fault;
   logic                 sat_err;
   logic [CNT_W-1:0]     peak;

   modport master (
      output outer, inner,
      input  enter_pulse, exit_pulse, count, full, empty, gate_fault, sat_err, peak
   );

   modport slave (
      input  outer, inner,
      output enter_pulse, exit_pulse, count, full, empty, gate_fault, sat_err, peak
   );

endinterface

// File: rtl/parking_lot_ctrl_gate_fsm.sv
// One gate: 2-flop sensor synchronizer, entry/exit direction FSM, registered
// pulses and sticky fault flag for illegal two-bit sensor jumps.
module gate_fsm
   import parking_pkg::*;
(
   input  logic clk,
   input  logic reset_n,
   input  logic outer,
   input  logic inner,
   output logic enter_pulse,
   output logic exit_pulse,
   output logic gate_fault
);

   logic [1:0]  sync_p0;
   logic [1:0]  sync_p1;
   gate_state_t state;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_p0     <= CLR;
         sync_p1     <= CLR;
         state       <= IDLE;
         enter_pulse <= 1'b0;
         exit_pulse  <= 1'b0;
         gate_fault  <= 1'b0;
      end else begin
         // synchronizer stages
         sync_p0     <= {outer, inner};
         sync_p1     <= sync_p0;
         enter_pulse <= 1'b0;
         exit_pulse  <= 1'b0;
         // every single-bit change is either a forward or a backward step, so
         // only a two-bit change needs separate handling
         if ((sync_p1 ^ state_code(state)) == BOTH) begin
            state      <= IDLE;
            gate_fault <= 1'b1;
         end else begin
            case (state)
               IDLE: if (sync_p1 == OUT) state <= EN1;
                     else if (sync_p1 == IN) state <= EX1;
               EN1:  if (sync_p1 == BOTH) state <= EN2;
                     else if (sync_p1 == CLR) state <= IDLE;
               EN2:  if (sync_p1 == IN) state <= EN3;
                     else if (sync_p1 == OUT) state <= EN1;
               EN3:  if (sync_p1 == CLR) begin
                        state       <= IDLE;
                        enter_pulse <= 1'b1;
                     end else if (sync_p1 == BOTH) state <= EN2;
               EX1:  if (sync_p1 == BOTH) state <= EX2;
                     else if (sync_p1 == CLR) state <= IDLE;
               EX2:  if (sync_p1 == OUT) state <= EX3;
                     else if (sync_p1 == IN) state <= EX1;
               EX3:  if (sync_p1 == CLR) begin
                        state      <= IDLE;
                        exit_pulse <= 1'b1;
                     end else if (sync_p1 == BOTH) state <= EX2;
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: rtl/parking_lot_ctrl.sv
// Multi-gate parking-lot controller: per-gate FSMs feed a saturating occupancy
// counter. Optional peak tracking is built when PARKING_PEAK_TRACK_EN is defined.
module parking_lot_ctrl
   import parking_pkg::*;
#(
   parameter int NUM_GATES = 2,
   parameter int CAPACITY  = 16,
   localparam int CNT_W    = $clog2(CAPACITY + 1)
) (
   input logic clk,
   input logic reset_n,
   parking_lot_ctrl_if.slave bus
);

   localparam int SUM_W = CNT_W + 4;
   localparam logic signed [SUM_W-1:0] CAP_S = SUM_W'(CAPACITY);

   logic [NUM_GATES-1:0]     enter_vec;
   logic [NUM_GATES-1:0]     exit_vec;
   logic [NUM_GATES-1:0]     fault_vec;
   logic [CNT_W-1:0]         count_q;
   logic                     sat_q;
   logic signed [SUM_W-1:0]  sum_p0;
   logic                     sat_now;

   function automatic logic signed [SUM_W-1:0] popcount(input logic [NUM_GATES-1:0] v);
      logic signed [SUM_W-1:0] n;
      n = '0;
      for (int i = 0; i < NUM_GATES; i++) n = n + SUM_W'(v[i]);
      return n;
   endfunction

   function automatic logic [CNT_W-1:0] clamp(input logic signed [SUM_W-1:0] x);
      if (x < 0)          return '0;
      else if (x > CAP_S) return CNT_W'(CAPACITY);
      else                return x[CNT_W-1:0];
   endfunction

   for (genvar g = 0; g < NUM_GATES; g++) begin : g_gate
      gate_fsm u_gate (
         .clk         (clk),
         .reset_n     (reset_n),
         .outer       (bus.outer[g]),
         .inner       (bus.inner[g]),
         .enter_pulse (enter_vec[g]),
         .exit_pulse  (exit_vec[g]),
         .gate_fault  (fault_vec[g])
      );
   end

   // merge stage: simultaneous events from all gates net out before clamping
   always_comb begin
      sum_p0  = $signed({4'b0000, count_q}) + popcount(enter_vec) - popcount(exit_vec);
      sat_now = (sum_p0 < 0) || (sum_p0 > CAP_S);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= '0;
         sat_q   <= 1'b0;
      end else begin
         count_q <= clamp(sum_p0);
         if (sat_now) sat_q <= 1'b1;
      end
   end

`ifdef PARKING_PEAK_TRACK_EN
   logic [CNT_W-1:0] peak_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)              peak_q <= '0;
      else if (count_q > peak_q) peak_q <= count_q;
   end

   assign bus.peak = peak_q;
`else
   assign bus.peak = '0;
`endif

   assign bus.enter_pulse = enter_vec;
   assign bus.exit_pulse  = exit_vec;
   assign bus.gate_fault  = fault_vec;
   assign bus.count       = count_q;
   assign bus.sat_err     = sat_q;
   assign bus.full        = (count_q == CNT_W'(CAPACITY));
   assign bus.empty       = (count_q == '0);

endmodule
